// File: rtl/rp_asg_burst_gen.sv
// rp_asg_burst_gen: one ASG channel with waveform table, burst FSM and gain/offset/saturation.
// Optional macro ASG_SWEEP_EN adds a linearly swept step (port set_step_inc_i).
module rp_asg_burst_gen #(
  parameter int DW  = 14,
  parameter int RSZ = 14,
  parameter int FW  = 16
) (
  input  logic                  dac_clk_i,
  input  logic                  dac_rst_i,
  input  logic                  trig_i,
  input  logic                  buf_we_i,
  input  logic [RSZ-1:0]        buf_addr_i,
  input  logic [DW-1:0]         buf_wdata_i,
  output logic [DW-1:0]         buf_rdata_o,
  input  logic [RSZ+FW-1:0]     set_size_i,
  input  logic [RSZ+FW-1:0]     set_step_i,
`ifdef ASG_SWEEP_EN
  input  logic [RSZ+FW-1:0]     set_step_inc_i,
`endif
  input  logic [RSZ+FW-1:0]     set_ofs_i,
  input  logic                  set_wrap_i,
  input  logic                  set_burst_i,
  input  logic [15:0]           set_ncyc_i,
  input  logic [15:0]           set_rnum_i,
  input  logic [31:0]           set_rdly_i,
  input  logic [31:0]           set_last_len_i,
  input  logic                  set_rst_i,
  input  logic [DW-1:0]         set_amp_i,
  input  logic [DW-1:0]         set_dc_i,
  input  logic [DW-1:0]         set_first_i,
  input  logic [DW-1:0]         set_last_i,
  output logic [DW-1:0]         dac_o,
  output logic                  trig_done_o,
  output logic                  busy_o,
  output logic [2:0]            state_o,
  output logic [RSZ-1:0]        buf_rpnt_o
);
  localparam int PW = RSZ + FW;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RUN   = 3'd1;
  localparam logic [2:0] ST_LAST  = 3'd2;
  localparam logic [2:0] ST_DELAY = 3'd3;
  localparam logic [1:0] SRC_TAB   = 2'd0;
  localparam logic [1:0] SRC_FIRST = 2'd1;
  localparam logic [1:0] SRC_LAST  = 2'd2;
  localparam logic signed [2*DW+1:0] SMAX = (2*DW+2)'((1 << (DW-1)) - 1);
  localparam logic signed [2*DW+1:0] SMIN = ~SMAX;

  logic [DW-1:0] mem [0:(1<<RSZ)-1];
  logic [DW-1:0] rd_q, rdata_q;

  logic [2:0]    state_q, state_d;
  logic [PW-1:0] pnt_q, pnt_d;
  logic [15:0]   cyc_q, cyc_d, rep_q, rep_d;
  logic [31:0]   len_q, len_d;
  logic          hold_q, hold_d, done_q, done_d;
  logic          go_run, go_end, wrap_hit;
  logic [PW:0]   nxt;
  logic [PW-1:0] rem, step;

`ifdef ASG_SWEEP_EN
  logic [PW-1:0] step_q, step_d;
  logic [PW+1:0] step_sum;
  assign step = step_q;
  assign step_sum = {2'b00, step_q}
                  + {{2{set_step_inc_i[PW-1]}}, set_step_inc_i};
`else
  assign step = set_step_i;
`endif

  assign nxt      = {1'b0, pnt_q} + {1'b0, step};
  assign wrap_hit = nxt > {1'b0, set_size_i};
  assign rem      = nxt[PW-1:0] - set_size_i - PW'(1);

  always_comb begin
    state_d = state_q;
    pnt_d   = pnt_q;
    cyc_d   = cyc_q;
    rep_d   = rep_q;
    len_d   = len_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    go_run  = 1'b0;
    go_end  = 1'b0;
`ifdef ASG_SWEEP_EN
    step_d  = step_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (trig_i) begin
          go_run = 1'b1;
          rep_d  = set_rnum_i;
          hold_d = 1'b0;
          done_d = 1'b1;
        end
      end
      ST_RUN: begin
`ifdef ASG_SWEEP_EN
        if (step_sum[PW+1] || step_sum == '0) step_d = PW'(1);
        else if (step_sum[PW]) step_d = '1;
        else step_d = step_sum[PW-1:0];
`endif
        if (wrap_hit) begin
          pnt_d = set_wrap_i ? rem : set_ofs_i;
          if (set_burst_i) begin
            cyc_d = cyc_q - 16'd1;
            if (cyc_q == 16'd1) begin
              if (set_last_len_i == 32'd0) begin
                go_end = 1'b1;
              end else begin
                state_d = ST_LAST;
                len_d   = set_last_len_i;
              end
            end
          end
        end else begin
          pnt_d = nxt[PW-1:0];
        end
      end
      ST_LAST: begin
        if (len_q <= 32'd1) go_end = 1'b1;
        else len_d = len_q - 32'd1;
      end
      ST_DELAY: begin
        if (len_q <= 32'd1) go_run = 1'b1;
        else len_d = len_q - 32'd1;
      end
      default: state_d = ST_IDLE;
    endcase
    // END is resolved in the same cycle it is reached
    if (go_end) begin
      if (rep_q == 16'd0) begin
        state_d = ST_IDLE;
        hold_d  = 1'b1;
      end else begin
        if (rep_q != 16'hFFFF) rep_d = rep_q - 16'd1;
        if (set_rdly_i != 32'd0) begin
          state_d = ST_DELAY;
          len_d   = set_rdly_i;
        end else begin
          go_run = 1'b1;
        end
      end
    end
    if (go_run) begin
      state_d = ST_RUN;
      pnt_d   = set_ofs_i;
      cyc_d   = (set_ncyc_i == 16'd0) ? 16'd1 : set_ncyc_i;
`ifdef ASG_SWEEP_EN
      step_d  = set_step_i;
`endif
    end
    if (set_rst_i) begin
      state_d = ST_IDLE;
      pnt_d   = set_ofs_i;
      cyc_d   = '0;
      rep_d   = '0;
      len_d   = '0;
      hold_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge dac_clk_i) begin
    if (dac_rst_i) begin
      state_q <= ST_IDLE;
      pnt_q   <= '0;
      cyc_q   <= '0;
      rep_q   <= '0;
      len_q   <= '0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef ASG_SWEEP_EN
      step_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      pnt_q   <= pnt_d;
      cyc_q   <= cyc_d;
      rep_q   <= rep_d;
      len_q   <= len_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
`ifdef ASG_SWEEP_EN
      step_q  <= step_d;
`endif
    end
  end

  always_ff @(posedge dac_clk_i) begin
    if (buf_we_i) mem[buf_addr_i] <= buf_wdata_i;
  end

  always_ff @(posedge dac_clk_i) begin
    if (dac_rst_i) begin
      rd_q    <= '0;
      rdata_q <= '0;
    end else begin
      rd_q    <= mem[pnt_q[PW-1:FW]];
      rdata_q <= mem[buf_addr_i];
    end
  end

  logic [1:0]               src, sel1_q;
  logic signed [DW-1:0]     smp_q, dac_q, dac_d;
  logic signed [2*DW:0]     smp_x, amp_x, prod, prod_q;
  logic signed [2*DW+1:0]   sum;

  always_comb begin
    src = SRC_LAST;
    if (state_q == ST_RUN) src = SRC_TAB;
    else if (state_q == ST_IDLE && !hold_q) src = SRC_FIRST;
  end

  assign smp_x = (2*DW+1)'(smp_q);
  assign amp_x = (2*DW+1)'({1'b0, set_amp_i});
  assign prod  = (smp_x * amp_x) >>> (DW-1);

  always_comb begin
    sum = (2*DW+2)'(prod_q) + (2*DW+2)'($signed(set_dc_i));
    if (sum > SMAX) dac_d = SMAX[DW-1:0];
    else if (sum < SMIN) dac_d = SMIN[DW-1:0];
    else dac_d = sum[DW-1:0];
  end

  always_ff @(posedge dac_clk_i) begin
    if (dac_rst_i) begin
      sel1_q <= SRC_FIRST;
      smp_q  <= '0;
      prod_q <= '0;
      dac_q  <= '0;
    end else begin
      sel1_q <= src;
      if (sel1_q == SRC_TAB) smp_q <= rd_q;
      else if (sel1_q == SRC_FIRST) smp_q <= set_first_i;
      else smp_q <= set_last_i;
      prod_q <= prod;
      dac_q  <= dac_d;
    end
  end

  assign dac_o       = dac_q;
  assign trig_done_o = done_q;
  assign busy_o      = state_q != ST_IDLE;
  assign state_o     = state_q;
  assign buf_rpnt_o  = pnt_q[PW-1:FW];
  assign buf_rdata_o = rdata_q;
endmodule

// File: doc/rp_asg_burst_gen.md
Name: rp_asg_burst_gen

Overview:
- Parametrised successor of the Red Pitaya ASG channel datapath and FSM.
- One arbitrary-waveform channel with a generic sample width, table depth and fractional pointer width.
- Explicit burst FSM: first value, run, last-value hold, inter-repetition delay.
- Sits between the ASG register bank (trigger already qualified upstream) and the DAC output mux. Instantiated once per channel.

Parameters:
- DW, 14, sample/DAC width (signed two's complement).
- RSZ, 14, table address bits; table holds 2^RSZ samples.
- FW, 16, fractional bits of the read pointer.

Ports:
- dac_clk_i  in  1  sole clock.
- dac_rst_i  in  1  synchronous, active-high reset.
- trig_i  in  1  qualified trigger pulse.
- buf_we_i  in  1  table write enable.
- buf_addr_i  in  RSZ  table address (write and read-back).
- buf_wdata_i  in  DW  table write data.
- buf_rdata_o  out  DW  table read-back, 1-cycle latency.
- set_size_i  in  RSZ+FW  last valid pointer value (size-1, fixed point).
- set_step_i  in  RSZ+FW  pointer increment per sample.
- set_ofs_i  in  RSZ+FW  start pointer.
- set_wrap_i  in  1  1 = wrap keeps the remainder; 0 = wrap reloads set_ofs_i.
- set_burst_i  in  1  0 = continuous, 1 = burst.
- set_ncyc_i  in  16  table periods per burst; 0 is treated as 1.
- set_rnum_i  in  16  extra repetitions; 16'hFFFF = infinite.
- set_rdly_i  in  32  delay between repetitions, in clock cycles.
- set_last_len_i  in  32  last-value hold length, in cycles.
- set_rst_i  in  1  soft reset.
- set_amp_i  in  DW  unsigned gain; 2^(DW-1) = unity.
- set_dc_i  in  DW  signed offset.
- set_first_i  in  DW  output before the first trigger.
- set_last_i  in  DW  output after the burst.
- dac_o  out  DW  scaled, saturated sample.
- trig_done_o  out  1  one-cycle pulse when a trigger is accepted.
- busy_o  out  1  FSM not in IDLE.
- state_o  out  3  FSM state: IDLE=0, RUN=1, LAST=2, DELAY=3.
- buf_rpnt_o  out  RSZ  integer part of the read pointer.

Behaviour:
- Reset (dac_rst_i=1): state IDLE, pointer = 0, all counters 0, hold flag 0.
  - Outputs: dac_o=0, trig_done_o=0, busy_o=0, state_o=0, buf_rpnt_o=0, buf_rdata_o=0.
- set_rst_i: same effect as reset, except pointer = set_ofs_i and the output selects set_first_i.
  - Has priority over trig_i in the same cycle.
- IDLE:
  - Output source is set_first_i, or set_last_i if the hold flag is set.
  - On trig_i: go to RUN, pointer = set_ofs_i, cyc_cnt = max(set_ncyc_i,1), rep_cnt = set_rnum_i, hold flag cleared, trig_done_o pulses.
- RUN:
  - Output source is table[pointer integer part]; each cycle nxt = pnt + step (RSZ+FW+1 bits).
  - If nxt > set_size_i (period wrap): pnt = set_wrap_i ? nxt - set_size_i - 1 : set_ofs_i.
    - In burst mode, cyc_cnt decrements on each wrap.
    - On the wrap where cyc_cnt==1: go to LAST, or to END if set_last_len_i==0.
  - Continuous mode never leaves RUN except via set_rst_i.
- LAST: output set_last_i for set_last_len_i cycles, then END.
- END (transient, not a state):
  - rep_cnt==0: go to IDLE, hold flag set.
  - Otherwise: decrement rep_cnt (unless 16'hFFFF); go to DELAY if set_rdly_i>0, else directly to RUN with pointer reload.
- DELAY:
  - Output set_last_i for set_rdly_i cycles.
  - Then RUN with pointer = set_ofs_i and cyc_cnt reloaded.
- trig_i outside IDLE is ignored. trig_done_o=0 on ignored triggers.
- Table:
  - Write-synchronous.
  - Read port has 1-cycle latency.
  - A write and a read to the same address in the same cycle returns the old data.
- Datapath (fixed pipeline, 4 cycles from pointer/state register to dac_o; the source select is delayed by a matching shift register):
  1. RAM read.
  2. Source mux.
  3. product = sample * {0,amp}, signed 2DW+1 bits, arithmetic shift right by DW-1.
  4. sum = product + dc; saturate to [-2^(DW-1), 2^(DW-1)-1].
- Config inputs are sampled every cycle; changes mid-burst take effect immediately, with no glitch protection.

Optional Feature:
- Macro: ASG_SWEEP_EN.
- With the macro defined:
  - Adds port set_step_inc_i, input, signed RSZ+FW bits.
  - The active step loads set_step_i at every RUN entry, then adds set_step_inc_i each RUN cycle.
  - The step saturates at 1 and at 2^(RSZ+FW)-1.
- Without the macro: the port is absent and the step equals set_step_i.

Test Plan:
- Table ramp 0..15; size=15<<16, step=1<<16, amp=8192, dc=0, burst, ncyc=2, rnum=0, last_len=3, last=100.
  -> After trig: dac_o = 0..15 twice, starting 4 cycles after RUN; then 100 for 3 cycles and held; trig_done_o pulses once.
- As above, rnum=1, rdly=5.
  -> Two bursts separated by 3+5 cycles of 100; state sequence RUN, LAST, DELAY, RUN, LAST, IDLE.
- step=3<<15 (1.5), size=15<<16.
  - wrap=1: index 0,1,3,4,6,7,9,10,12,13,15,0 (remainder carried).
  - wrap=0: index 0,1,3,4,...,15,0 (reload to set_ofs_i).
- table value 8191, amp=16383, dc=100 -> dac_o saturates at 8191; table -8192, dc=-1 -> dac_o = -8192.
- set_rst_i and trig_i asserted together in RUN -> IDLE next cycle, dac_o = first after pipeline; trig_done_o stays 0.
- ASG_SWEEP_EN: step=1<<16, inc=1<<12 -> pointer increment grows by 1/16 per cycle; reset to 1<<16 on the next burst start.
